// File: rtl/xor_table_update_stage.sv
// Read-modify-write front end for the XOR hash table: issues reads, XORs request data into
// the returned row two cycles later, sweeps clears, reports updates. Optional stats: XOR_UPDATE_STATS_EN.
module xor_table_update_stage #(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INDEX_WIDTH-1:0]        in_index,
  input  logic [NUM_MUL-1:0]            in_lane_mask,
  input  logic [NUM_MUL*DATA_WIDTH-1:0] in_data,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic [INDEX_WIDTH-1:0]        rd_index,
  output logic                          write_reg_0_valid,
  output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
  input  logic [NUM_MUL*DATA_WIDTH-1:0] rd_out_update,
  output logic [NUM_MUL-1:0]            arbiter_result,
  output logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor,
  output logic                          upd_valid,
  output logic [INDEX_WIDTH-1:0]        upd_index,
  output logic [NUM_MUL*DATA_WIDTH-1:0] upd_data,
  output logic [31:0]                   stat_ops,
  output logic [31:0]                   stat_lane_writes
);

  localparam int RowW = NUM_MUL * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_e;

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] clr_cnt_q;
  logic                   drain_cnt_q;
  logic                   in_ready_q;
  logic [INDEX_WIDTH-1:0] rd_index_q;

  logic                   s1_valid_q, s1_clr_q, s2_valid_q, s2_clr_q;
  logic [NUM_MUL-1:0]     s1_mask_q, s2_mask_q;
  logic [RowW-1:0]        s1_data_q, s2_data_q;
  logic [INDEX_WIDTH-1:0] s1_index_q, s2_index_q;

  logic                   upd_valid_q;
  logic [INDEX_WIDTH-1:0] upd_index_q;
  logic [RowW-1:0]        upd_data_q;

  logic                   issue_req, issue_clr;
  logic [INDEX_WIDTH-1:0] issue_index;

  assign issue_req = in_valid && in_ready_q;
  assign issue_clr = (state_q == CLEAR);

  // in_ready is low in CLEAR, so a clear slot and a request never coincide
  always_comb begin
    issue_index = rd_index_q;
    if (issue_clr) begin
      issue_index = clr_cnt_q;
    end else if (issue_req) begin
      issue_index = in_index;
    end
  end

  assign in_ready          = in_ready_q;
  assign clear_busy        = (state_q != IDLE);
  assign rd_index          = issue_index;
  assign write_reg_0_index = issue_index;
  assign write_reg_0_valid = issue_req || issue_clr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      drain_cnt_q <= 1'b0;
      in_ready_q  <= 1'b0;
      rd_index_q  <= '0;
    end else begin
      rd_index_q <= issue_index;
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == '1) begin
            state_q     <= DRAIN;
            clr_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          in_ready_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q <= IDLE;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_mask_q  <= '0;
      s1_data_q  <= '0;
      s1_index_q <= '0;
      s2_valid_q <= 1'b0;
      s2_clr_q   <= 1'b0;
      s2_mask_q  <= '0;
      s2_data_q  <= '0;
      s2_index_q <= '0;
    end else begin
      s1_valid_q <= write_reg_0_valid;
      s1_clr_q   <= issue_clr;
      s1_mask_q  <= in_lane_mask;
      s1_data_q  <= in_data;
      s1_index_q <= issue_index;
      s2_valid_q <= s1_valid_q;
      s2_clr_q   <= s1_clr_q;
      s2_mask_q  <= s1_mask_q;
      s2_data_q  <= s1_data_q;
      s2_index_q <= s1_index_q;
    end
  end

  // rd_out_update already carries forwarded in-flight writes, so no hazard stall is needed
  always_comb begin
    arbiter_result   = '0;
    write_reg_11_xor = '0;
    if (s2_valid_q) begin
      if (s2_clr_q) begin
        arbiter_result = '1;
      end else begin
        arbiter_result = s2_mask_q;
        for (int i = 0; i < NUM_MUL; i++) begin
          write_reg_11_xor[i*DATA_WIDTH +: DATA_WIDTH] = rd_out_update[i*DATA_WIDTH +: DATA_WIDTH]
            ^ (s2_mask_q[i] ? s2_data_q[i*DATA_WIDTH +: DATA_WIDTH] : '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_valid_q <= 1'b0;
      upd_index_q <= '0;
      upd_data_q  <= '0;
    end else begin
      upd_valid_q <= s2_valid_q && !s2_clr_q;
      if (s2_valid_q && !s2_clr_q) begin
        upd_index_q <= s2_index_q;
        upd_data_q  <= write_reg_11_xor;
      end
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_index = upd_index_q;
  assign upd_data  = upd_data_q;

`ifdef XOR_UPDATE_STATS_EN
  localparam int PopW = $clog2(NUM_MUL + 1);

  logic [31:0]   stat_ops_q, stat_lanes_q;
  logic [PopW-1:0] mask_pop;
  logic [32:0]   lane_sum;

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < NUM_MUL; i++) begin
      mask_pop = mask_pop + PopW'(in_lane_mask[i]);
    end
    lane_sum = {1'b0, stat_lanes_q} + 33'(mask_pop);
  end

  // Both counters saturate rather than wrap
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_ops_q   <= '0;
      stat_lanes_q <= '0;
    end else if (issue_req) begin
      if (stat_ops_q != '1) begin
        stat_ops_q <= stat_ops_q + 32'd1;
      end
      stat_lanes_q <= lane_sum[32] ? '1 : lane_sum[31:0];
    end
  end

  assign stat_ops         = stat_ops_q;
  assign stat_lane_writes = stat_lanes_q;
`else
  assign stat_ops         = '0;
  assign stat_lane_writes = '0;
`endif

endmodule

// File: tb/tb_xor_table_update_stage.sv
// Scoreboard bench for xor_table_update_stage: a row-level table model predicts each write-back
// and update report; a small memory model closes the read/forward loop around the DUT.
module tb_xor_table_update_stage;

  localparam int NM    = 4;
  localparam int IW    = 4;
  localparam int DW    = 16;
  localparam int RW    = NM * DW;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_index = '0;
  logic [NM-1:0] in_lane_mask = '0;
  logic [RW-1:0] in_data = '0;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic [IW-1:0] rd_index;
  logic          write_reg_0_valid;
  logic [IW-1:0] write_reg_0_index;
  logic [RW-1:0] rd_out_update;
  logic [NM-1:0] arbiter_result;
  logic [RW-1:0] write_reg_11_xor;
  logic          upd_valid;
  logic [IW-1:0] upd_index;
  logic [RW-1:0] upd_data;
  logic [31:0]   stat_ops;
  logic [31:0]   stat_lane_writes;

  always #5 clk = ~clk;

  xor_table_update_stage #(.NUM_MUL(NM), .INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_lane_mask(in_lane_mask), .in_data(in_data),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .rd_index(rd_index), .write_reg_0_valid(write_reg_0_valid),
    .write_reg_0_index(write_reg_0_index), .rd_out_update(rd_out_update),
    .arbiter_result(arbiter_result), .write_reg_11_xor(write_reg_11_xor),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_data(upd_data),
    .stat_ops(stat_ops), .stat_lane_writes(stat_lane_writes)
  );

  typedef struct { logic [NM-1:0] mask; logic [RW-1:0] row; } wb_t;
  typedef struct { logic [IW-1:0] idx;  logic [RW-1:0] row; } up_t;

  wb_t           wbQ[$];
  up_t           upQ[$];
  logic [RW-1:0] refMem [DEPTH];
  logic [RW-1:0] mem    [DEPTH];
  int            checks = 0;
  int            failures = 0;
  int            expOps = 0;
  int            expLanes = 0;

  function automatic logic [RW-1:0] seedRow(int i);
    logic [RW-1:0] r;
    r = '0;
    if (i == 9) begin
      for (int l = 0; l < NM; l++) r[l*DW +: DW] = 16'h00FF;
    end else if (i != 5 && i != 7) begin
      for (int l = 0; l < NM; l++) r[l*DW +: DW] = 16'((i * 37 + l * 101) * 257) ^ 16'hA5C3;
    end
    return r;
  endfunction

  // Table memory: delayed issue index addresses the row presented at the write stage; a
  // write lands at the end of that cycle, so the next op already sees it (forwarding).
  logic          preloaded = 1'b0;
  logic          vP1 = 1'b0, vP2 = 1'b0;
  logic [IW-1:0] iP1 = '0, iP2 = '0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seedRow(i);
      preloaded <= 1'b1;
    end else if (!reset) begin
      vP1 <= 1'b0;
      vP2 <= 1'b0;
    end else begin
      vP1 <= write_reg_0_valid;
      iP1 <= write_reg_0_index;
      vP2 <= vP1;
      iP2 <= iP1;
      if (vP2) begin
        for (int l = 0; l < NM; l++) begin
          if (arbiter_result[l]) mem[iP2][l*DW +: DW] <= write_reg_11_xor[l*DW +: DW];
        end
      end
    end
  end

  assign rd_out_update = mem[iP2];

  task automatic checkOutput(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write-back or update report is presented
  always @(negedge clk) begin
    if (reset && preloaded) begin
      if (vP2) begin
        if (wbQ.size() == 0) begin
          checkOutput("wb_unexpected", RW'(arbiter_result), '0);
          if (arbiter_result == '0) checkOutput("wb_unexpected", 1, 0);
        end else begin
          wb_t e;
          e = wbQ.pop_front();
          checkOutput("wb_enable", RW'(arbiter_result), RW'(e.mask));
          checkOutput("wb_data", write_reg_11_xor, e.row);
        end
      end else begin
        checkOutput("wb_idle_enable", RW'(arbiter_result), '0);
        checkOutput("wb_idle_data", write_reg_11_xor, '0);
      end
      if (upd_valid) begin
        if (upQ.size() == 0) begin
          checkOutput("upd_unexpected", 1, 0);
        end else begin
          up_t u;
          u = upQ.pop_front();
          checkOutput("upd_index", RW'(upd_index), RW'(u.idx));
          checkOutput("upd_data", upd_data, u.row);
        end
      end
    end
  end

  task automatic modelRequest(input logic [IW-1:0] idx, input logic [NM-1:0] m, input logic [RW-1:0] d);
    logic [RW-1:0] row;
    row = refMem[idx];
    for (int l = 0; l < NM; l++) begin
      if (m[l]) row[l*DW +: DW] = row[l*DW +: DW] ^ d[l*DW +: DW];
    end
    refMem[idx] = row;
    wbQ.push_back('{m, row});
    upQ.push_back('{idx, row});
    expOps++;
    expLanes += $countones(m);
  endtask

  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) begin
      wbQ.push_back('{'1, '0});
      refMem[i] = '0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IW-1:0] idx, input logic [NM-1:0] m,
                               input logic [RW-1:0] d, input logic clr);
    @(posedge clk);
    #1;
    in_valid     = v;
    in_index     = idx;
    in_lane_mask = m;
    in_data      = d;
    clear_start  = clr;
    if (v && in_ready) modelRequest(idx, m, d);
    if (clr && !clear_busy) modelClear();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic waitIdle();
    int c;
    c = 0;
    while (clear_busy && c < 100) begin
      idle(1);
      c++;
    end
    if (c >= 100) checkOutput("wait_clear_timeout", 1, 0);
    idle(4);
  endtask

  task automatic checkStats();
`ifdef XOR_UPDATE_STATS_EN
    checkOutput("stat_ops", RW'(stat_ops), RW'(expOps));
    checkOutput("stat_lane_writes", RW'(stat_lane_writes), RW'(expLanes));
`else
    checkOutput("stat_ops", RW'(stat_ops), '0);
    checkOutput("stat_lane_writes", RW'(stat_lane_writes), '0);
`endif
  endtask

  task automatic runClear();
    int busy, lowReady;
    waitIdle();
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    busy = 0;
    lowReady = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0);
      if (clear_busy) busy++;
      if (!in_ready) lowReady++;
    end
    checkOutput("clear_busy_cycles", RW'(busy), RW'(DEPTH + 2));
    checkOutput("ready_low_cycles", RW'(lowReady), RW'(DEPTH));
  endtask

  initial begin
    logic [RW-1:0] lane1One, lane1Two;
    lane1One = RW'(1) << DW;
    lane1Two = RW'(2) << DW;
    for (int i = 0; i < DEPTH; i++) refMem[i] = seedRow(i);

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", RW'(in_ready), '0);
    checkOutput("rst_clear_busy", RW'(clear_busy), '0);
    checkOutput("rst_wr0_valid", RW'(write_reg_0_valid), '0);
    checkOutput("rst_rd_index", RW'(rd_index), '0);
    checkOutput("rst_wr0_index", RW'(write_reg_0_index), '0);
    checkOutput("rst_arbiter", RW'(arbiter_result), '0);
    checkOutput("rst_wb_data", write_reg_11_xor, '0);
    checkOutput("rst_upd_valid", RW'(upd_valid), '0);
    checkOutput("rst_upd_index", RW'(upd_index), '0);
    checkOutput("rst_upd_data", upd_data, '0);
    checkOutput("rst_stat_ops", RW'(stat_ops), '0);
    checkOutput("rst_stat_lanes", RW'(stat_lane_writes), '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", RW'(in_ready), 1);

    // Directed: single update, forwarding back-to-back, read-only, repeat update
    applyStimulus(1'b1, 4'd5, 4'b0001, RW'(16'hA5), 1'b0);
    idle(3);
    applyStimulus(1'b1, 4'd7, 4'b0010, lane1One, 1'b0);
    applyStimulus(1'b1, 4'd7, 4'b0010, lane1Two, 1'b0);
    applyStimulus(1'b1, 4'd9, 4'b0000, {$urandom, $urandom}, 1'b0);
    idle(2);
    applyStimulus(1'b1, 4'd5, 4'b0001, RW'(16'hA5), 1'b0);
    idle(5);
    checkStats();
    checkOutput("rd_index_holds", RW'(rd_index), RW'(5));

    // Full clear, then randomized traffic with occasional clear requests
    runClear();
    for (int n = 0; n < 300; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, IW'($urandom), NM'($urandom),
                    {$urandom, $urandom}, $urandom_range(0, 99) == 0);
    end
    waitIdle();
    checkStats();

    // Reset in the middle of a clear sweep
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        if (write_reg_0_valid && write_reg_0_index == 4'd6) found = 1'b1;
      end
      checkOutput("clear_reaches_6", RW'(found), 1);
    end
    reset = 1'b0;
    wbQ.delete();
    upQ.delete();
    expOps = 0;
    expLanes = 0;
    idle(2);
    reset = 1'b1;
    idle(1);
    checkOutput("post_reset_ready", RW'(in_ready), 1);
    checkOutput("post_reset_busy", RW'(clear_busy), '0);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      checkOutput("post_reset_no_issue", RW'(write_reg_0_valid), '0);
    end

    // Fresh clear restores a known table, then the statistics scenario
    runClear();
    applyStimulus(1'b1, 4'd2, 4'b1111, {$urandom, $urandom}, 1'b0);
    applyStimulus(1'b1, 4'd3, 4'b0011, {$urandom, $urandom}, 1'b0);
    applyStimulus(1'b1, 4'd2, 4'b0000, {$urandom, $urandom}, 1'b0);
    idle(6);
    checkStats();
`ifdef XOR_UPDATE_STATS_EN
    checkOutput("stat_ops_three", RW'(stat_ops), RW'(3));
    checkOutput("stat_lanes_six", RW'(stat_lane_writes), RW'(6));
`endif

    waitIdle();
    checkOutput("wb_queue_drained", RW'(wbQ.size()), '0);
    checkOutput("upd_queue_drained", RW'(upQ.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_table_update_stage.md
# xor_table_update_stage

Read-modify-write front end for the XOR hash table memory block. It accepts update requests (one table index plus per-lane data and a lane mask), issues the table read and write-pipeline entry, and aligns the returned, forwarding-corrected row with the request. It then XORs the request data into the enabled lanes and drives the write-back data and per-lane write enables two cycles after issue. It also owns a table-clear sweep and reports each completed update downstream.

## Interface
Parameters:
- NUM_MUL, 4, number of lanes per table row
- INDEX_WIDTH, 12, table index width; table depth = 2^INDEX_WIDTH
- DATA_WIDTH, 64, bits per lane

Ports:
- clk  in  1  single clock, all logic posedge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- in_valid  in  1  update request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_index  in  INDEX_WIDTH  table row to update
- in_lane_mask  in  NUM_MUL  lanes to modify
- in_data  in  NUM_MUL*DATA_WIDTH  per-lane XOR operand, lane i at [i*DATA_WIDTH+:DATA_WIDTH]
- clear_start  in  1  one-cycle pulse requesting a full-table clear
- clear_busy  out  1  high while the clear is in progress
- rd_index  out  INDEX_WIDTH  table read address, to memory block
- write_reg_0_valid  out  1  write-pipeline entry valid, to memory block
- write_reg_0_index  out  INDEX_WIDTH  write-pipeline entry index, to memory block
- rd_out_update  in  NUM_MUL*DATA_WIDTH  forwarding-corrected row, from memory block
- arbiter_result  out  NUM_MUL  per-lane write enables for the write stage
- write_reg_11_xor  out  NUM_MUL*DATA_WIDTH  write-back row
- upd_valid  out  1  completed-update report valid
- upd_index  out  INDEX_WIDTH  row of the completed update
- upd_data  out  NUM_MUL*DATA_WIDTH  new row value
- stat_ops  out  32  accepted updates (see Configuration)
- stat_lane_writes  out  32  enabled lane writes (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, DRAIN. Reset state: IDLE.
- IDLE:
  - in_ready=1.
  - An accepted request at cycle t drives rd_index=write_reg_0_index=in_index and write_reg_0_valid=1 combinationally in cycle t.
  - The request is tagged as op (mask, data) into stage s1 at t+1 and s2 at t+2.
- Write stage, at t+2 for an s2 op:
  - Lane i: write_reg_11_xor = rd_out_update ^ data when mask[i]; otherwise it passes rd_out_update through unchanged.
  - arbiter_result = mask.
- Read-only ops: an accepted request with mask==0 is still issued, writes no lane, and reports the old row.
- Idle cycles: when s2 is empty, arbiter_result=0 and write_reg_11_xor=0. When no request is issued, write_reg_0_valid=0 and rd_index holds its last value.
- Clear:
  - clear_start in IDLE moves to CLEAR. clear_start is ignored in CLEAR or DRAIN.
  - A request in the same cycle as clear_start is accepted; clear begins the next cycle.
  - CLEAR: in_ready=0. Issue index counter 0,1,..,2^INDEX_WIDTH-1, one per cycle, tagged clear.
  - A clear-tagged s2 op drives arbiter_result all ones and write_reg_11_xor all zeros.
  - After the last index is issued, go to DRAIN for 2 cycles, then IDLE.
  - clear_busy=1 in CLEAR and DRAIN.
- Reporting: upd_valid/upd_index/upd_data are registered from the s2 op at t+3. Clear ops are not reported.
- Back-to-back updates to the same index need no stall; the memory block forwards in-flight write data into rd_out_update.
- Reset mid-operation: all in-flight ops are discarded, FSM returns to IDLE, and the clear counter returns to 0. A partial clear is not resumed.

## Timing
- Issue to write-back: 2 cycles, matching the write_reg_0 to write_reg_11 distance. Issue to upd_valid: 3 cycles.
- Throughput: 1 request per cycle in IDLE.
- Clear duration: 2^INDEX_WIDTH + 2 cycles with clear_busy high.
- Reset values: in_ready=0, clear_busy=0, write_reg_0_valid=0, rd_index=0, write_reg_0_index=0, arbiter_result=0, write_reg_11_xor=0, upd_valid=0, upd_index=0, upd_data=0, stat_*=0.
- in_ready rises the first cycle after reset is released.

## Configuration
- XOR_UPDATE_STATS_EN defined:
  - stat_ops increments per accepted request.
  - stat_lane_writes adds popcount(mask) per accepted request.
  - Both saturate at 2^32-1. Clear ops are not counted.
- XOR_UPDATE_STATS_EN undefined: counters are not built; stat_ops and stat_lane_writes are constant 0.

## Test plan
- After reset, update idx 5, mask 4'b0001, lane0 data 0xA5 -> write-back at t+2 with arbiter_result=0001, lane0 0xA5. A second identical update later -> upd_data lane0 = 0.
- Back-to-back updates to idx 7 (lane1 0x1, then 0x2) on consecutive cycles -> second write-back lane1 = 0x3 via forwarding. upd_data lane1 = 0x1, then 0x3.
- Mask 0 to idx 9 holding 0xFF -> arbiter_result=0, upd_data equals 0xFF. stat_lane_writes is unchanged.
- clear_start with INDEX_WIDTH=4 -> clear_busy high 18 cycles, in_ready low 16 cycles, 16 all-lane zero writes. All subsequent reads return 0.
- reset low during CLEAR at index 6 -> on release, FSM IDLE, in_ready=1, no further writes.
- With XOR_UPDATE_STATS_EN, 3 updates with masks 1111, 0011, 0000 -> stat_ops=3, stat_lane_writes=6. Without the macro, both read 0.
